// File: rtl/waterfall_scroller.sv
// Scrolling waterfall: ring-offset frame-buffer reads in video, one bin line copied per scroll.
// Define WATERFALL_CLEAR_EN to zero the frame buffer after reset.
module waterfall_scroller #(
  parameter int H_VISIBLE = 320,
  parameter int V_VISIBLE = 240,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int FB_ADDR_W = 17,
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [X_W-1:0]       x,
  input  logic [Y_W-1:0]       y,
  input  logic                 lower_blank,
  input  logic [DIV_W-1:0]     scroll_div,
  input  logic                 freeze,
  output logic [X_W-1:0]       bin_addr,
  output logic                 bin_rd,
  input  logic [DATA_W-1:0]    bin_data,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0]    fb_wdata,
  output logic                 fb_wen,
  output logic [Y_W-1:0]       y_offset,
  output logic                 busy,
  output logic                 line_done
);

  typedef enum logic [1:0] {CLEAR, VIDEO, WRITE, WAIT_BLANK} state_t;

  localparam int CNT_W = X_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(H_VISIBLE);
  localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_VISIBLE);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_VISIBLE - 1);
  localparam logic [FB_ADDR_W-1:0] H_MUL = FB_ADDR_W'(H_VISIBLE);
`ifdef WATERFALL_CLEAR_EN
  localparam state_t RST_ST = CLEAR;
  localparam logic [FB_ADDR_W-1:0] CLR_LAST =
    FB_ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
`else
  localparam state_t RST_ST = VIDEO;
`endif

  state_t state, state_n;
  logic [FB_ADDR_W-1:0] addr_n, rd_addr, row_base;
  logic [X_W-1:0] bin_addr_n;
  logic [Y_W-1:0] yoff_n, y_mod;
  logic [Y_W:0] y_sum;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic wen_n, rd_n, done_n, pass, pass_n;
  logic blank_q, blank_d, blank_edge;

  // Ring mapping: display row y shows stored row (y + y_offset) mod V
  assign y_sum = {1'b0, y} + {1'b0, y_offset};
  assign y_mod = (y_sum >= V_LIM) ? Y_W'(y_sum - V_LIM) : y_sum[Y_W-1:0];
  assign rd_addr = FB_ADDR_W'(x) + FB_ADDR_W'(y_mod) * H_MUL;
  assign row_base = FB_ADDR_W'(y_offset) * H_MUL;

  assign blank_edge = blank_q & ~blank_d;
  assign busy = (state == CLEAR) || (state == WRITE);
  // BRAM data arrives in the same cycle as its write strobe
  assign fb_wdata = pass ? bin_data : '0;

  always_comb begin
    state_n = state;
    addr_n = fb_addr;
    wen_n = 1'b0;
    pass_n = 1'b0;
    bin_addr_n = bin_addr;
    rd_n = 1'b0;
    yoff_n = y_offset;
    done_n = 1'b0;
    div_n = div_cnt;
    cnt_n = cnt;
    case (state)
`ifdef WATERFALL_CLEAR_EN
      CLEAR: begin
        if (!fb_wen) begin
          wen_n = 1'b1;
          addr_n = '0;
        end else if (fb_addr == CLR_LAST) begin
          state_n = VIDEO;
        end else begin
          wen_n = 1'b1;
          addr_n = fb_addr + 1'b1;
        end
      end
`endif
      VIDEO: begin
        addr_n = rd_addr;
        if (blank_edge) begin
          state_n = WAIT_BLANK;
          if (!freeze && div_cnt >= scroll_div) begin
            div_n = '0;
            state_n = WRITE;
            bin_addr_n = '0;
            rd_n = 1'b1;
            cnt_n = '0;
          end else if (!freeze) begin
            div_n = div_cnt + 1'b1;
          end
        end
      end
      WRITE: begin
        if (cnt == LAST) begin
          state_n = WAIT_BLANK;
          done_n = 1'b1;
          yoff_n = (y_offset == V_LAST) ? '0 : y_offset + 1'b1;
        end else begin
          wen_n = 1'b1;
          pass_n = 1'b1;
          addr_n = row_base + FB_ADDR_W'(cnt);
          cnt_n = cnt + 1'b1;
          if (cnt < LAST - 1'b1) begin
            rd_n = 1'b1;
            bin_addr_n = X_W'(cnt + 1'b1);
          end
        end
      end
      WAIT_BLANK: begin
        if (!lower_blank) state_n = VIDEO;
      end
      default: state_n = VIDEO;
    endcase
  end

  // Edge history resets high so a blank already active is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST_ST;
      fb_addr <= '0;
      fb_wen <= 1'b0;
      pass <= 1'b0;
      bin_addr <= '0;
      bin_rd <= 1'b0;
      y_offset <= '0;
      line_done <= 1'b0;
      div_cnt <= '0;
      cnt <= '0;
      blank_q <= 1'b1;
      blank_d <= 1'b1;
    end else begin
      state <= state_n;
      fb_addr <= addr_n;
      fb_wen <= wen_n;
      pass <= pass_n;
      bin_addr <= bin_addr_n;
      bin_rd <= rd_n;
      y_offset <= yoff_n;
      line_done <= done_n;
      div_cnt <= div_n;
      cnt <= cnt_n;
      blank_q <= lower_blank;
      blank_d <= blank_q;
    end
  end

endmodule

// File: tb/tb_waterfall_scroller.sv
// Directed bench for waterfall_scroller: mapping, line copy, ring wrap, divider/freeze, reset.
// Builds with WATERFALL_CLEAR_EN use an 8x4 geometry to exercise the clear sweep.
module tb_waterfall_scroller;
`ifdef WATERFALL_CLEAR_EN
  localparam int H = 8, V = 4, XW = 4, YW = 3, AW = 5;
  localparam bit CLR = 1'b1;
`else
  localparam int H = 320, V = 24, XW = 9, YW = 5, AW = 13;
  localparam bit CLR = 1'b0;
`endif
  localparam int DW = 8, DVW = 2;
  localparam int MID = (H > 100) ? 100 : H / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [XW-1:0] x = '0;
  logic [YW-1:0] y = '0;
  logic lower_blank = 1'b0;
  logic [DVW-1:0] scroll_div = '0;
  logic freeze = 1'b0;
  logic [XW-1:0] bin_addr;
  logic bin_rd;
  logic [DW-1:0] bin_data = '0;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_wdata;
  logic fb_wen;
  logic [YW-1:0] y_offset;
  logic busy;
  logic line_done;

  int checks = 0;
  int passes = 0;

  waterfall_scroller #(
    .H_VISIBLE(H), .V_VISIBLE(V), .X_W(XW), .Y_W(YW),
    .FB_ADDR_W(AW), .DATA_W(DW), .DIV_W(DVW)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .lower_blank(lower_blank), .scroll_div(scroll_div),
    .freeze(freeze), .bin_addr(bin_addr), .bin_rd(bin_rd),
    .bin_data(bin_data), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_wen(fb_wen), .y_offset(y_offset), .busy(busy),
    .line_done(line_done)
  );

  always #5 clk = ~clk;

  // Bin BRAM returns its own index, one cycle latency
  always @(posedge clk) if (bin_rd) bin_data <= DW'(bin_addr);

  // One blanking pulse; records writes, bad address/data writes, line_done pulses
  task automatic pulse(input int row, input int hold, input int frz_at,
                       output int nwr, output int ndone, output int nbad);
    int span;
    span = ((hold > H + 3) ? hold : H + 3) + 4;
    nwr = 0; ndone = 0; nbad = 0;
    @(negedge clk);
    lower_blank = 1'b1;
    for (int i = 0; i < span; i++) begin
      @(negedge clk);
      if (i == hold) lower_blank = 1'b0;
      if (i == frz_at) freeze = 1'b1;
      if (fb_wen === 1'b1) begin
        if (fb_addr !== AW'(row * H + nwr) || fb_wdata !== DW'(nwr)) nbad++;
        nwr++;
      end
      if (line_done === 1'b1) ndone++;
    end
  endtask

  task automatic do_reset(input logic lb);
    x = '0; y = '0; freeze = 1'b0; lower_blank = lb;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < H * V + 8; i++) begin
      if (busy !== 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) $display("FAIL ready: busy=%0d expected 0", busy);
    else passes++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fb_addr !== '0) $display("FAIL rst_fb_addr: got %0d expected 0", fb_addr); else passes++;
    checks++; if (fb_wen !== 1'b0) $display("FAIL rst_fb_wen: got %0d expected 0", fb_wen); else passes++;
    checks++; if (fb_wdata !== '0) $display("FAIL rst_fb_wdata: got %0d expected 0", fb_wdata); else passes++;
    checks++; if (bin_rd !== 1'b0) $display("FAIL rst_bin_rd: got %0d expected 0", bin_rd); else passes++;
    checks++; if (bin_addr !== '0) $display("FAIL rst_bin_addr: got %0d expected 0", bin_addr); else passes++;
    checks++; if (y_offset !== '0) $display("FAIL rst_y_offset: got %0d expected 0", y_offset); else passes++;
    checks++; if (line_done !== 1'b0) $display("FAIL rst_line_done: got %0d expected 0", line_done); else passes++;
    checks++; if (busy !== CLR) $display("FAIL rst_busy: got %0d expected %0d", busy, CLR); else passes++;
  endtask

  task automatic test_clear;
    int nw, nbad;
    bit idle;
    nw = 0; nbad = 0; idle = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < H * V + H + 8; i++) begin
      @(negedge clk);
      if (fb_wen === 1'b1) begin
        if (fb_addr !== AW'(nw) || fb_wdata !== '0) nbad++;
        nw++;
      end
      if (CLR && busy === 1'b0) begin idle = 1'b1; break; end
    end
    if (!CLR) idle = (busy === 1'b0);
    checks++;
    if (nw !== (CLR ? H * V : 0)) $display("FAIL clear_count: got %0d expected %0d", nw, CLR ? H * V : 0);
    else passes++;
    checks++; if (nbad !== 0) $display("FAIL clear_addr_data: got %0d bad expected 0", nbad); else passes++;
    checks++; if (idle !== 1'b1) $display("FAIL clear_busy_done: got %0d expected 1", idle); else passes++;
  endtask

  task automatic test_read_mapping;
    int xs[3] = '{5, H - 1, 7};
    int ys[3] = '{3, V - 1, 1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x = XW'(xs[i]); y = YW'(ys[i]);
      @(negedge clk);
      checks++;
      if (fb_addr !== AW'(ys[i] * H + xs[i]))
        $display("FAIL read_map_%0d: got %0d expected %0d", i, fb_addr, ys[i] * H + xs[i]);
      else passes++;
    end
    x = '0; y = '0;
  endtask

  task automatic test_line_write;
    int nwr, ndone, nbad;
    scroll_div = '0;
    pulse(0, H + 3, -1, nwr, ndone, nbad);
    checks++; if (nwr !== H) $display("FAIL line_writes: got %0d expected %0d", nwr, H); else passes++;
    checks++; if (nbad !== 0) $display("FAIL line_addr_data: got %0d bad expected 0", nbad); else passes++;
    checks++; if (ndone !== 1) $display("FAIL line_done: got %0d expected 1", ndone); else passes++;
    checks++; if (y_offset !== YW'(1)) $display("FAIL line_yoff: got %0d expected 1", y_offset); else passes++;
    checks++; if (fb_wen !== 1'b0 || bin_rd !== 1'b0) $display("FAIL line_idle: got wen=%0d rd=%0d expected 0 0", fb_wen, bin_rd); else passes++;
  endtask

  task automatic test_blank_fall_freeze;
    int nwr, ndone, nbad;
    pulse(1, 2, H / 2, nwr, ndone, nbad);
    freeze = 1'b0;
    checks++; if (nwr !== H) $display("FAIL fall_writes: got %0d expected %0d", nwr, H); else passes++;
    checks++; if (nbad !== 0) $display("FAIL fall_addr_data: got %0d bad expected 0", nbad); else passes++;
    checks++; if (ndone !== 1) $display("FAIL fall_done: got %0d expected 1", ndone); else passes++;
    checks++; if (y_offset !== YW'(2 % V)) $display("FAIL fall_yoff: got %0d expected %0d", y_offset, 2 % V); else passes++;
  endtask

  task automatic test_reset_mid_write;
    int nwr, ndone, nbad;
    bit found;
    found = 1'b0;
    scroll_div = '0;
    @(negedge clk);
    lower_blank = 1'b1;
    for (int i = 0; i < H + 10; i++) begin
      @(negedge clk);
      if (bin_rd === 1'b1 && bin_addr === XW'(MID)) begin found = 1'b1; break; end
    end
    checks++; if (found !== 1'b1) $display("FAIL midw_reach_bin: got %0d expected 1", found); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (fb_wen !== 1'b0) $display("FAIL midw_fb_wen: got %0d expected 0", fb_wen); else passes++;
    checks++; if (bin_rd !== 1'b0) $display("FAIL midw_bin_rd: got %0d expected 0", bin_rd); else passes++;
    checks++; if (y_offset !== '0) $display("FAIL midw_yoff: got %0d expected 0", y_offset); else passes++;
    checks++; if (busy !== CLR) $display("FAIL midw_busy: got %0d expected %0d", busy, CLR); else passes++;
    do_reset(1'b0);
    pulse(0, H + 3, -1, nwr, ndone, nbad);
    checks++; if (ndone !== 1 || nwr !== H || nbad !== 0)
      $display("FAIL midw_restart: got done=%0d wr=%0d bad=%0d expected 1 %0d 0", ndone, nwr, nbad, H);
    else passes++;
  endtask

  task automatic test_wrap;
    int nwr, ndone, nbad, tw, tb, ex;
    tw = 0; tb = 0;
    do_reset(1'b0);
    scroll_div = '0;
    for (int k = 1; k <= V; k++) begin
      pulse(k - 1, H + 3, -1, nwr, ndone, nbad);
      tw += nwr; tb += nbad;
      ex = (k == V) ? 0 : k;
      checks++;
      if (y_offset !== YW'(ex)) $display("FAIL wrap_yoff_%0d: got %0d expected %0d", k, y_offset, ex);
      else passes++;
      if (k == V - 1) begin
        @(negedge clk); x = XW'(5); y = YW'(3);
        @(negedge clk);
        checks++;
        if (fb_addr !== AW'(2 * H + 5)) $display("FAIL wrap_read_y3: got %0d expected %0d", fb_addr, 2 * H + 5);
        else passes++;
        y = '0;
        @(negedge clk);
        checks++;
        if (fb_addr !== AW'((V - 1) * H + 5)) $display("FAIL wrap_read_y0: got %0d expected %0d", fb_addr, (V - 1) * H + 5);
        else passes++;
        x = '0;
      end
    end
    checks++; if (tw !== V * H) $display("FAIL wrap_writes: got %0d expected %0d", tw, V * H); else passes++;
    checks++; if (tb !== 0) $display("FAIL wrap_addr_data: got %0d bad expected 0", tb); else passes++;
  endtask

  task automatic test_divider;
    int nwr, ndone, nbad, row, ex;
    row = 0;
    do_reset(1'b0);
    scroll_div = DVW'(3);
    for (int e = 1; e <= 24; e++) begin
      freeze = (e >= 13 && e <= 20);
      pulse(row, H + 3, -1, nwr, ndone, nbad);
      ex = (e == 4 || e == 8 || e == 12 || e == 24) ? 1 : 0;
      checks++;
      if (ndone !== ex || nwr !== ex * H || nbad !== 0)
        $display("FAIL div_edge_%0d: got done=%0d wr=%0d bad=%0d expected %0d %0d 0", e, ndone, nwr, nbad, ex, ex * H);
      else passes++;
      if (ex == 1) row = (row + 1) % V;
    end
    freeze = 1'b0;
    checks++; if (y_offset !== YW'(4 % V)) $display("FAIL div_yoff: got %0d expected %0d", y_offset, 4 % V); else passes++;
  endtask

  task automatic test_div_change;
    int nwr, ndone, nbad, row;
    int divs[5] = '{3, 3, 1, 1, 1};
    int exps[5] = '{0, 0, 1, 0, 1};
    row = 4 % V;
    for (int i = 0; i < 5; i++) begin
      scroll_div = DVW'(divs[i]);
      pulse(row, H + 3, -1, nwr, ndone, nbad);
      checks++;
      if (ndone !== exps[i] || nbad !== 0)
        $display("FAIL divchg_%0d: got done=%0d bad=%0d expected %0d 0", i, ndone, nbad, exps[i]);
      else passes++;
      if (exps[i] == 1) row = (row + 1) % V;
    end
  endtask

  task automatic test_blank_high_at_reset;
    int nw, nd, nwr, ndone, nbad;
    nw = 0; nd = 0;
    scroll_div = '0;
    do_reset(1'b1);
    for (int i = 0; i < H + 6; i++) begin
      @(negedge clk);
      if (fb_wen === 1'b1) nw++;
      if (line_done === 1'b1) nd++;
    end
    checks++; if (nw !== 0 || nd !== 0) $display("FAIL high_at_entry: got wr=%0d done=%0d expected 0 0", nw, nd); else passes++;
    lower_blank = 1'b0;
    repeat (3) @(negedge clk);
    pulse(0, H + 3, -1, nwr, ndone, nbad);
    checks++; if (ndone !== 1 || nwr !== H || nbad !== 0)
      $display("FAIL high_then_edge: got done=%0d wr=%0d bad=%0d expected 1 %0d 0", ndone, nwr, nbad, H);
    else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_clear;
    test_read_mapping;
    test_line_write;
    test_blank_fall_freeze;
    test_reset_mid_write;
    test_wrap;
    test_divider;
    test_div_change;
    test_blank_high_at_reset;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
